rr_grant_fsm: RTL
=================

// Module: rr_grant_fsm
// PURPOSE
//  Multi-channel request/grant/revoke controller: IDLE -> REQUESTING -> GRANT -> REVOKE.
//  Generalises the single-channel handshake FSM to N_CH requesters.
//  Adds round-robin selection, a hold-timeout that forces revocation when others wait,
//  and a fixed revoke guard interval. Sits between requesting agents and a shared resource.
// PARAMETERS
//  N_CH          4   number of requesting channels (>=2)
//  HOLD_CYCLES   16  max GRANT cycles before forced revoke while another channel requests (>=1)
//  GUARD_CYCLES  2   REVOKE duration in cycles (>=1)
// PORTS
//  i_ck        in   1        clock, all logic on posedge
//  i_srst      in   1        synchronous active-high reset
//  i_req       in   N_CH     per-channel request level; drop = release
//  o_grant     out  N_CH     one-hot grant, valid only in GRANT
//  o_revoke    out  N_CH     one-hot revoke notice to the last grantee, asserted in REVOKE
//  o_grantId   out  $clog2(N_CH)  index of current/last grantee
//  o_timeout   out  1        1-cycle pulse when GRANT ends by timeout
//  o_state     out  2        current state encoding (debug)
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset (i_srst=1 at posedge):
//   - state=IDLE, rr pointer=0, hold/guard counters=0, o_grantId=0.
//   - o_grant=0, o_revoke=0, o_timeout=0.
//   - Reset overrides every transition, including mid-GRANT and mid-REVOKE.
//  State transitions (all registered, one per cycle max):
//   - IDLE: |i_req -> REQUESTING; else stay.
//   - REQUESTING: pick the first set bit of i_req at or after the rr pointer, wrapping N_CH-1 -> 0.
//     - If a bit is found: latch its index into o_grantId, set pointer=(idx+1) mod N_CH, clear hold, -> GRANT.
//     - If i_req==0 (withdrawn): -> IDLE, no grant, pointer unchanged.
//   - GRANT: o_grant[o_grantId]=1. Hold counter increments, saturating at HOLD_CYCLES.
//     - If i_req[o_grantId]==0 (release): -> REVOKE.
//     - Else if hold==HOLD_CYCLES-1 and any other i_req bit is set: -> REVOKE, with o_timeout pulse on that cycle.
//     - Else stay.
//     - Release and timeout in the same cycle count as release: no o_timeout.
//     - With no competitors the grant is held indefinitely and the counter saturates.
//   - REVOKE: o_grant=0, o_revoke[o_grantId]=1. Guard counter runs 0..GUARD_CYCLES-1, then -> IDLE.
//     - i_req is ignored during REVOKE.
//  Latency:
//   - Request to grant: 2 cycles (IDLE->REQUESTING->GRANT).
//   - Release to o_grant low: 1 cycle.
//   - Minimum spacing between grants: GUARD_CYCLES+2 cycles.
//  Outputs:
//   - o_grant, o_revoke and o_state decode from registered state and o_grantId only; glitch-free, no input paths.
//   - o_timeout is registered.
//   - o_grant and o_revoke are never both nonzero.
//   - At most one bit of o_grant is set.
//  Illegal state encodings -> IDLE on the next cycle.
//  Counter widths:
//   - hold: $clog2(HOLD_CYCLES+1).
//   - guard: $clog2(GUARD_CYCLES+1).
//   - No wrap permitted.
// STRUCTURE
//  Package rr_grant_pkg holds:
//   - ty_STATE_FSM enum logic[1:0] {STATE_IDLE, STATE_REQUESTING, STATE_GRANT, STATE_REVOKE}.
//   - A helper function for the one-hot decode of the grant index.
//  Sub-module rr_pick (combinational):
//   - Inputs: i_req[N_CH], i_ptr.
//   - Outputs: o_found, o_idx.
//   - Rotate, priority-encode, un-rotate.
//  Top level contains only the FSM, the counters and the pointer register.
// TESTING
//  1. i_req=0001 held -> o_grant=0001 two cycles after req; hold it 40 cycles -> no timeout, grant stays.
//  2. i_req=1111 from reset, each grantee drops req after 3 GRANT cycles.
//     - Required grant order: ch0, ch1, ch2, ch3, ch0.
//     - Each revoke lasts 2 cycles.
//  3. ch1 granted, ch2 requests, ch1 never drops:
//     - After 16 GRANT cycles: o_timeout pulses once, o_revoke=0010.
//     - Next grant is ch2.
//  4. Req pulses 1 cycle only, dropping in REQUESTING -> returns to IDLE, o_grant never asserts, pointer unchanged.
//  5. i_srst asserted mid-GRANT and mid-REVOKE:
//     - Next cycle: o_grant=0, o_revoke=0, state=IDLE.
//     - Next grant starts from ch0.
//  6. Release and timeout coincide on cycle 16 -> REVOKE entered, o_timeout stays 0.

Source files
------------

// File: rtl/rr_grant_pkg.sv
// rtl/rr_grant_pkg.sv - shared types and helpers for the round-robin grant controller
package rr_grant_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE       = 2'd0,
    STATE_REQUESTING = 2'd1,
    STATE_GRANT      = 2'd2,
    STATE_REVOKE     = 2'd3
  } ty_STATE_FSM;

  // One bit of the one-hot decode of a grant index: 1 when bit position pos is the grantee
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return (idx == pos);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker (rotate, priority-encode, un-rotate)
module rr_pick #(
  parameter int N_CH = 4,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);

  logic [N_CH-1:0] rot;
  logic [IW:0]     src;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // Rotate so the pointer lands on bit 0, take the lowest set bit, then map back to a channel
  always_comb begin
    rot = '0;
    src = '0;
    for (int c = 0; c < N_CH; c++) begin
      src = {1'b0, i_ptr} + (IW+1)'(c);
      if (src >= (IW+1)'(N_CH)) src = src - (IW+1)'(N_CH);
      rot[c] = i_req[src[IW-1:0]];
    end
    o_found = |rot;
    off = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (rot[c]) off = IW'(c);
    end
    sum = {1'b0, i_ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N_CH)) sum = sum - (IW+1)'(N_CH);
    o_idx = sum[IW-1:0];
  end

endmodule

// File: rtl/rr_grant_fsm.sv
// rtl/rr_grant_fsm.sv - multi-channel request/grant/revoke controller with round-robin and hold timeout
module rr_grant_fsm
  import rr_grant_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int GUARD_CYCLES = 2,
  localparam int IW = $clog2(N_CH),
  localparam int HW = $clog2(HOLD_CYCLES + 1),
  localparam int GW = $clog2(GUARD_CYCLES + 1)
) (
  input  logic            i_ck,
  input  logic            i_srst,
  input  logic [N_CH-1:0] i_req,
  output logic [N_CH-1:0] o_grant,
  output logic [N_CH-1:0] o_revoke,
  output logic [IW-1:0]   o_grantId,
  output logic            o_timeout,
  output logic [1:0]      o_state
);

  ty_STATE_FSM   state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          timeout_q, timeout_d;

  logic [N_CH-1:0] gid_oh;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     ptr_next;
  logic            req_mine;
  logic            req_others;

  rr_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  // Decode the registered grantee index and split requests into "mine" and "competitors"
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      gid_oh[c] = onehot_bit(32'(grant_id_q), 32'(c));
    end
    req_mine   = |(i_req & gid_oh);
    req_others = |(i_req & ~gid_oh);
    ptr_next   = {1'b0, pick_idx} + (IW+1)'(1);
    if (ptr_next >= (IW+1)'(N_CH)) ptr_next = '0;
  end

  // State, pointer, counters and timeout flag; reset wins over every transition
  always_ff @(posedge i_ck) begin
    if (i_srst) begin
      state_q    <= STATE_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      hold_q     <= '0;
      guard_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
      guard_q    <= guard_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: release beats timeout, timeout only fires when someone else waits
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    guard_d    = guard_q;
    timeout_d  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (|i_req) state_d = STATE_REQUESTING;
      end
      STATE_REQUESTING: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          ptr_d      = ptr_next[IW-1:0];
          hold_d     = '0;
          state_d    = STATE_GRANT;
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_GRANT: begin
        if (hold_q != HW'(HOLD_CYCLES)) hold_d = hold_q + 1'b1;
        if (!req_mine) begin
          state_d = STATE_REVOKE;
          guard_d = '0;
        end else if (hold_q == HW'(HOLD_CYCLES - 1) && req_others) begin
          state_d   = STATE_REVOKE;
          guard_d   = '0;
          timeout_d = 1'b1;
        end
      end
      STATE_REVOKE: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = STATE_IDLE;
          guard_d = '0;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // Outputs decode from registered state and grantee only
  always_comb begin
    o_grant   = (state_q == STATE_GRANT)  ? gid_oh : '0;
    o_revoke  = (state_q == STATE_REVOKE) ? gid_oh : '0;
    o_grantId = grant_id_q;
    o_timeout = timeout_q;
    o_state   = state_q;
  end

endmodule
